nvm_writer: RTL and testbench

NVM_WRITER -- requirements
Module: nvm_writer

---
 rtl/nvm_writer_if.sv | 16 +
 rtl/nvm_writer.sv | 91 +++++++++
 tb/tb_nvm_writer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/nvm_writer_if.sv
// Frame-input, readback and status bundle for the serial NVM writer.
interface nvm_writer_if #(
    parameter int ADDR_W = 5
);
    logic              Write;
    logic [ADDR_W-1:0] Addr;
    logic              DIN;
    logic [ADDR_W-1:0] RAddr;
    logic [7:0]        RData;
    logic              Busy;
    logic              Done;
    logic              Err;

    modport master (output Write, Addr, DIN, RAddr, input RData, Busy, Done, Err);
    modport slave  (input Write, Addr, DIN, RAddr, output RData, Busy, Done, Err);
endinterface

// File: rtl/nvm_writer.sv
// Serial byte writer: start/8 data LSB-first/stop frame stored into a small
// register-file memory with combinational readback.
module nvm_writer #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input logic         CLK,
    input logic         RST,
    nvm_writer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

    state_t            state, state_nxt;
    logic [2:0]        cnt;
    logic [7:0]        shreg;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        mem [DEPTH];
    logic              done_q, err_q;
    logic              start, shift, wr, done_nxt, err_nxt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    // Dropping Write in DATA or STOP abandons the frame silently.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        shift     = 1'b0;
        wr        = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Write && !bus.DIN) begin
                    start     = 1'b1;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (!bus.Write) begin
                    state_nxt = IDLE;
                end else begin
                    shift = 1'b1;
                    if (cnt == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                state_nxt = IDLE;
                if (bus.Write) begin
                    if (bus.DIN) begin
                        wr       = 1'b1;
                        done_nxt = 1'b1;
                    end else begin
                        err_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt    <= '0;
            shreg  <= '0;
            addr_q <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            done_q <= done_nxt;
            err_q  <= err_nxt;
            if (start) begin
                addr_q <= bus.Addr;
                cnt    <= '0;
            end
            if (shift) begin
                shreg[cnt] <= bus.DIN;
                cnt        <= cnt + 3'd1;
            end
            if (wr) mem[addr_q] <= shreg;
        end
    end

    assign bus.RData = mem[bus.RAddr];
    assign bus.Busy  = (state != IDLE);
    assign bus.Done  = done_q;
    assign bus.Err   = err_q;
endmodule

// File: tb/tb_nvm_writer.sv
// Directed plus randomized frame bench for nvm_writer against a word-array model.
module tb_nvm_writer;
    logic CLK = 1'b0;
    logic RST = 1'b0;

    nvm_writer_if #(.ADDR_W(5)) bus ();

    nvm_writer #(.ADDR_W(5), .DEPTH(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int last_done  = 0;
    int first_done = 0;
    logic [7:0] ref_mem [32];

    always @(posedge CLK) cyc++;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic busy, input logic done, input logic err);
        check({tag, "_busy"}, {7'd0, bus.Busy}, {7'd0, busy});
        check({tag, "_done"}, {7'd0, bus.Done}, {7'd0, done});
        check({tag, "_err"},  {7'd0, bus.Err},  {7'd0, err});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        bus.Write = 1'b0;
        bus.DIN   = 1'b1;
        for (int k = 0; k < n; k++) begin
            tick();
            check_flags("idle", 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic check_all_mem(input string tag);
        for (int k = 0; k < 32; k++) begin
            bus.RAddr = k[4:0];
            #1;
            check(tag, bus.RData, ref_mem[k]);
        end
    endtask

    // abort_at: 0..7 drops Write instead of that data bit, 8 drops it at the stop bit.
    task automatic frame(input logic [4:0] a, input logic [7:0] d, input logic stopb,
                         input int abort_at, input logic use_alt, input logic [4:0] alt);
        bus.Write = 1'b1;
        bus.Addr  = a;
        bus.DIN   = 1'b0;
        tick();
        check_flags("start", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (use_alt) bus.Addr = alt;
            if (i == abort_at) begin
                bus.Write = 1'b0;
                bus.DIN   = 1'($urandom);
                tick();
                check_flags("abort_data", 1'b0, 1'b0, 1'b0);
                return;
            end
            bus.DIN = d[i];
            tick();
            check_flags("data", 1'b1, 1'b0, 1'b0);
        end
        if (abort_at == 8) begin
            bus.Write = 1'b0;
            bus.DIN   = 1'($urandom);
            tick();
            check_flags("abort_stop", 1'b0, 1'b0, 1'b0);
            return;
        end
        bus.DIN = stopb;
        tick();
        check_flags("stop", 1'b0, stopb, !stopb);
        if (stopb) begin
            ref_mem[a] = d;
            last_done  = cyc;
        end
        bus.RAddr = a;
        #1;
        check("rdata", bus.RData, ref_mem[a]);
    endtask

    initial begin
        for (int k = 0; k < 32; k++) ref_mem[k] = 8'h00;
        bus.Write = 1'b1;
        bus.Addr  = '0;
        bus.DIN   = 1'b0;
        bus.RAddr = '0;

        // Reset held with an active-looking bus
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            bus.DIN = ~bus.DIN;
            #1;
            check_flags("reset", 1'b0, 1'b0, 1'b0);
        end
        check_all_mem("reset_mem");
        @(negedge CLK);
        RST       = 1'b1;
        bus.Write = 1'b0;
        bus.DIN   = 1'b1;
        idle(2);

        frame(5'd1, 8'h02, 1'b1, -1, 1'b0, 5'd0);
        idle(2);

        frame(5'd3, 8'h06, 1'b1, -1, 1'b0, 5'd0);
        first_done = last_done;
        frame(5'd31, 8'h3E, 1'b1, -1, 1'b0, 5'd0);
        check("b2b_gap", 8'(last_done - first_done), 8'd10);
        idle(2);

        frame(5'd4, 8'hA5, 1'b0, -1, 1'b0, 5'd0);
        idle(2);

        frame(5'd7, 8'hFF, 1'b1, 5, 1'b0, 5'd0);
        idle(1);
        bus.RAddr = 5'd7;
        #1;
        check("abort_mem7", bus.RData, 8'h00);
        frame(5'd7, 8'h11, 1'b1, -1, 1'b0, 5'd0);
        idle(1);

        frame(5'd2, 8'h44, 1'b1, -1, 1'b1, 5'd9);
        bus.RAddr = 5'd9;
        #1;
        check("addr_stable_mem9", bus.RData, 8'h00);
        idle(1);

        // Reset in the middle of a frame
        bus.Write = 1'b1;
        bus.Addr  = 5'd12;
        bus.DIN   = 1'b0;
        tick();
        bus.DIN = 1'b1;
        tick();
        tick();
        #2;
        RST = 1'b0;
        #1;
        check_flags("rst_mid", 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 32; k++) ref_mem[k] = 8'h00;
        check_all_mem("rst_mid_mem");
        @(negedge CLK);
        RST = 1'b1;
        frame(5'd12, 8'h5A, 1'b1, -1, 1'b0, 5'd0);
        idle(1);

        for (int n = 0; n < 60; n++) begin
            logic [4:0] a;
            logic [7:0] d;
            logic       stopb;
            int         ab;
            a     = 5'($urandom);
            d     = 8'($urandom);
            stopb = ($urandom % 5) != 0;
            ab    = ($urandom % 6 == 0) ? int'($urandom_range(0, 8)) : -1;
            frame(a, d, stopb, ab, 1'($urandom), 5'($urandom));
            if ($urandom % 2 == 1) idle(int'($urandom_range(1, 3)));
        end
        idle(1);
        check_all_mem("final_mem");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
